// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES round sequencer.
//   seq_state_t  : sequencer FSM encoding (IDLE, ROUND, DONE)
//   AES_BLOCK_W  : AES block / round-key width in bits
//   AES128_NR    : round count for AES-128
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES128_NR   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

endpackage : aes_pkg

// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller. Accepts one block per valid/ready
// transaction, applies the initial AddRoundKey, then steps an external
// combinational round datapath through NR rounds while indexing the
// external round-key store, and presents the result until consumed.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      block input handshake (in_ready high only in IDLE)
//   in_encrypt, in_block   direction and block, sampled on accept
//   flush                  synchronous abort back to IDLE (highest priority)
//   rk_idx / rk            round-key index request / key returned same cycle
//   dp_state, dp_encrypt,  state register, latched direction and final-round
//   dp_last                flag driven to the round datapath
//   dp_result              datapath output for the current round
//   out_valid/out_ready    result handshake, out_block holds the result
//   busy                   high while a block is in ROUND or DONE
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NR       = AES128_NR,
  parameter int unsigned RK_IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_encrypt,
  input  logic [AES_BLOCK_W-1:0] in_block,
  input  logic                   flush,

  output logic [RK_IDX_W-1:0]    rk_idx,
  input  logic [AES_BLOCK_W-1:0] rk,

  output logic [AES_BLOCK_W-1:0] dp_state,
  output logic                   dp_encrypt,
  output logic                   dp_last,
  input  logic [AES_BLOCK_W-1:0] dp_result,

  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_block,
  output logic                   busy
);

  localparam logic [RK_IDX_W-1:0] NR_IDX   = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] ZERO_IDX = RK_IDX_W'(0);
  localparam logic [RK_IDX_W-1:0] ONE_IDX  = RK_IDX_W'(1);

  seq_state_t             state_q, state_d;
  logic [AES_BLOCK_W-1:0] data_q,  data_d;
  logic                   enc_q,   enc_d;
  logic [RK_IDX_W-1:0]    r_q,     r_d;

  logic                   last_round;

  assign last_round = (r_q == NR_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      enc_q   <= 1'b0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      enc_q   <= enc_d;
      r_q     <= r_d;
    end
  end

  // Next-state and datapath-control decode
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    enc_d   = enc_q;
    r_d     = r_q;
    rk_idx  = ZERO_IDX;
    dp_last = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Initial AddRoundKey uses key 0 forward, key NR backward.
        rk_idx = in_encrypt ? ZERO_IDX : NR_IDX;
        if (in_valid) begin
          state_d = ROUND;
          data_d  = in_block ^ rk;
          enc_d   = in_encrypt;
          r_d     = ONE_IDX;
        end
      end

      ROUND: begin
        rk_idx  = enc_q ? r_q : (NR_IDX - r_q);
        dp_last = last_round;
        data_d  = dp_result;
        if (last_round) begin
          state_d = DONE;
        end else begin
          r_d = r_q + ONE_IDX;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          r_d     = ZERO_IDX;
        end
      end

      default: begin
        state_d = IDLE;
        r_d     = ZERO_IDX;
      end
    endcase

    // Abort discards the in-flight block; state and direction are kept.
    if (flush) begin
      state_d = IDLE;
      data_d  = data_q;
      enc_d   = enc_q;
      r_d     = ZERO_IDX;
    end
  end

  // Status and data outputs decode straight from registers
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == ROUND) || (state_q == DONE);
  assign dp_state   = data_q;
  assign out_block  = data_q;
  assign dp_encrypt = enc_q;

endmodule : aes_round_sequencer

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies a behavioural AES round datapath
// and key schedule, runs FIPS-197 vectors from a table, then directed
// backpressure, back-to-back, flush and mid-operation reset sequences.
module tb_aes_round_sequencer;

  localparam int NR = 10;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_encrypt;
  logic [127:0] in_block;
  logic         flush;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] dp_state;
  logic         dp_encrypt;
  logic         dp_last;
  logic [127:0] dp_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;

  int n_cmp;
  int n_err;

  logic [7:0]   sbox   [256];
  logic [7:0]   isbox  [256];
  logic [127:0] rk_tab [11];
  int unsigned  tbl_gen;

  aes_round_sequencer #(.NR(10), .RK_IDX_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_encrypt (in_encrypt),
    .in_block   (in_block),
    .flush      (flush),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .dp_state   (dp_state),
    .dp_encrypt (dp_encrypt),
    .dp_last    (dp_last),
    .dp_result  (dp_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference AES model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
      isbox[sbox[x]] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]}
              ^ {rc, 24'h000000};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k <= 10; k++)
      rk_tab[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    tbl_gen = tbl_gen + 1;
  endtask

  function automatic logic [127:0] rk_lookup(input logic [3:0] idx, input int unsigned gen);
    if (gen == 0 || idx > 4'd10) return '0;
    return rk_tab[idx];
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic enc,
                                             input logic last, input logic [127:0] k);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = enc ? sbox[a[r+4*((c+r)%4)]] : isbox[a[r+4*((c-r+4)%4)]];
    if (!enc)
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    for (int i = 0; i < 16; i++) m[i] = t[i];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        if (enc) begin
          m[4*c]   = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
          m[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
          m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
          m[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
        end else begin
          m[4*c]   = gmul(t[4*c],8'h0e) ^ gmul(t[4*c+1],8'h0b) ^ gmul(t[4*c+2],8'h0d) ^ gmul(t[4*c+3],8'h09);
          m[4*c+1] = gmul(t[4*c],8'h09) ^ gmul(t[4*c+1],8'h0e) ^ gmul(t[4*c+2],8'h0b) ^ gmul(t[4*c+3],8'h0d);
          m[4*c+2] = gmul(t[4*c],8'h0d) ^ gmul(t[4*c+1],8'h09) ^ gmul(t[4*c+2],8'h0e) ^ gmul(t[4*c+3],8'h0b);
          m[4*c+3] = gmul(t[4*c],8'h0b) ^ gmul(t[4*c+1],8'h0d) ^ gmul(t[4*c+2],8'h09) ^ gmul(t[4*c+3],8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
    if (enc) o = o ^ k;
    return o;
  endfunction

  // External key store and round datapath
  assign rk        = rk_lookup(rk_idx, tbl_gen);
  assign dp_result = aes_round(dp_state, dp_encrypt, dp_last, rk);

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] blk;
    logic         enc;
    logic [127:0] exp;
    int           hold;
  } vec_t;

  vec_t vecs [4];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // One full transaction with per-round checks and optional DONE stall.
  task automatic run_txn(input vec_t v);
    logic [3:0] exp_idx;
    expand_key(v.key);
    in_block   = v.blk;
    in_encrypt = v.enc;
    in_valid   = 1'b1;
    #1;
    chk({v.name, " in_ready idle"}, 128'(in_ready), 128'(1));
    chk({v.name, " rk_idx idle"}, 128'(rk_idx), v.enc ? 128'(0) : 128'(NR));
    step();                                       // accept edge A
    in_valid = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      exp_idx = v.enc ? 4'(k) : 4'(NR - k);
      chk($sformatf("%s rk_idx r=%0d", v.name, k), 128'(rk_idx), 128'(exp_idx));
      chk($sformatf("%s dp_last r=%0d", v.name, k), 128'(dp_last), 128'(k == NR));
      chk($sformatf("%s out_valid early r=%0d", v.name, k), 128'(out_valid), 128'(0));
      chk($sformatf("%s busy/enc r=%0d", v.name, k), 128'({busy, dp_encrypt}), 128'({1'b1, v.enc}));
      step();
    end
    chk({v.name, " out_valid at A+NR"}, 128'(out_valid), 128'(1));
    chk({v.name, " out_block"}, out_block, v.exp);
    chk({v.name, " done in_ready/dp_last/rk_idx"}, 128'({in_ready, dp_last, rk_idx}), 128'(0));
    for (int h = 0; h < v.hold; h++) begin
      step();
      chk($sformatf("%s stall block h=%0d", v.name, h), out_block, v.exp);
      chk($sformatf("%s stall flags h=%0d", v.name, h),
          128'({out_valid, in_ready, busy}), 128'(3'b101));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({v.name, " release flags"}, 128'({in_ready, out_valid, busy}), 128'(3'b100));
  endtask

  task automatic test_back_to_back();
    int acc_edge;
    int n_out;
    int lat;
    expand_key(KEY_B);
    in_valid = 1'b1; in_encrypt = 1'b1; in_block = PT_B; out_ready = 1'b1;
    #1;
    chk("b2b first in_ready", 128'(in_ready), 128'(1));
    step();                                       // first accept
    in_encrypt = 1'b0; in_block = CT_B;
    acc_edge = 0; n_out = 0;
    for (int e = 1; e <= 20; e++) begin
      if (in_ready) acc_edge = e;
      if (out_valid) begin
        n_out++;
        chk("b2b first out_block", out_block, CT_B);
      end
      step();
      if (acc_edge != 0) break;
    end
    in_valid = 1'b0;
    chk("b2b accept spacing", 128'(acc_edge), 128'(12));
    chk("b2b first result count", 128'(n_out), 128'(1));
    lat = 0;
    for (int e = 1; e <= 20 && !out_valid; e++) begin
      step();
      lat = e;
    end
    chk("b2b second latency", 128'(lat), 128'(NR));
    chk("b2b second out_block", out_block, PT_B);
    step();
    out_ready = 1'b0;
    chk("b2b back to idle", 128'({in_ready, busy}), 128'(2'b10));
  endtask

  task automatic test_flush();
    logic [127:0] exp_st;
    int           n_ov;
    expand_key(KEY_C);
    exp_st = PT_C ^ rk_tab[0];
    for (int k = 1; k <= 3; k++) exp_st = aes_round(exp_st, 1'b1, 1'b0, rk_tab[k]);
    in_valid = 1'b1; in_encrypt = 1'b1; in_block = PT_C;
    step();                                       // accept, r=1
    in_valid = 1'b0;
    step(); step(); step();                       // r=4
    chk("flush rk_idx r=4", 128'(rk_idx), 128'(4));
    chk("flush state before", dp_state, exp_st);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush idle flags", 128'({in_ready, out_valid, busy, dp_last}), 128'(4'b1000));
    chk("flush state held", dp_state, exp_st);
    chk("flush enc held", 128'(dp_encrypt), 128'(1));
    n_ov = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n_ov++;
      step();
    end
    chk("flush no out_valid", 128'(n_ov), 128'(0));
    // flush also blocks an accept in IDLE
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush blocks accept", 128'({in_ready, busy}), 128'(2'b10));
  endtask

  task automatic test_reset_mid();
    expand_key(KEY_B);
    in_valid = 1'b1; in_encrypt = 1'b0; in_block = CT_B;
    step();                                       // accept, r=1
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();           // r=7
    chk("rst r=7 rk_idx", 128'(rk_idx), 128'(NR - 7));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async flags", 128'({in_ready, out_valid, busy, dp_last, dp_encrypt}), 128'(5'b10000));
    chk("rst async dp_state", dp_state, 128'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("rst released idle", 128'({in_ready, busy}), 128'(2'b10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; tbl_gen = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_encrypt = 1'b0; in_block = '0;
    flush = 1'b0; out_ready = 1'b0;

    vecs[0] = '{"enc_B", KEY_B, PT_B, 1'b1, CT_B, 0};
    vecs[1] = '{"dec_B", KEY_B, CT_B, 1'b0, PT_B, 0};
    vecs[2] = '{"enc_C", KEY_C, PT_C, 1'b1, CT_C, 5};
    vecs[3] = '{"dec_C", KEY_C, CT_C, 1'b0, PT_C, 0};

    build_sbox();
    #2;
    chk("reset flags", 128'({in_ready, out_valid, busy, dp_encrypt, dp_last}), 128'(5'b10000));
    chk("reset dp_state", dp_state, 128'(0));
    chk("reset out_block", out_block, 128'(0));
    chk("reset rk_idx", 128'(rk_idx), 128'(NR));
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);
    test_back_to_back();
    test_flush();
    run_txn(vecs[2]);
    test_reset_mid();
    run_txn(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_aes_round_sequencer

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES-128 round controller. It accepts one 128-bit block per transaction and owns the state register. It steps an external combinational round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey, with the encrypt flag routed to ShiftRows) through NR rounds, indexing the external round-key store each cycle. It sits between the block-level valid/ready interface and the round datapath, and serialises one block at a time.

## Interface
Parameters:
- NR, default 10: number of rounds (AES-128).
- RK_IDX_W, default 4: width of the round-key index; must hold NR.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  input block offered.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- in_encrypt  in  1  1 = encrypt, 0 = decrypt; sampled on accept.
- in_block  in  128  plaintext/ciphertext; sampled on accept.
- flush  in  1  synchronous abort.
- rk_idx  out  RK_IDX_W  round-key index requested this cycle (combinational).
- rk  in  128  round key for rk_idx, valid same cycle.
- dp_state  out  128  current state register to datapath.
- dp_encrypt  out  1  latched direction to datapath/ShiftRows.
- dp_last  out  1  final round: datapath skips (Inv)MixColumns.
- dp_result  in  128  datapath output for dp_state, dp_encrypt, dp_last, rk.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_block  out  128  result (equals dp_state in DONE).
- busy  out  1  high in ROUND or DONE.

## Operation
- FSM states: IDLE, ROUND, DONE.
- Registers: state[127:0], enc, round counter r (RK_IDX_W bits).
- IDLE:
  - in_ready = 1.
  - rk_idx = in_encrypt ? 0 : NR.
  - On in_valid: state <= in_block ^ rk, enc <= in_encrypt, r <= 1, go to ROUND.
- ROUND:
  - rk_idx = enc ? r : NR - r.
  - dp_last = (r == NR).
  - Each cycle: state <= dp_result.
  - If r == NR, go to DONE; otherwise r <= r + 1.
- DONE:
  - out_valid = 1; out_block and state are held.
  - On out_ready, go to IDLE; r <= 0.
  - No new accept in the same cycle.
- flush: has priority over all transitions. Next edge goes to IDLE with r <= 0; state and enc are held. In-flight result is discarded with no out_valid.
- Outputs outside their states:
  - dp_last = 0 outside ROUND.
  - rk_idx outside IDLE/ROUND = 0.
  - dp_encrypt = enc at all times.
- Counter never exceeds NR; no wrap.
- Reset value of every register is 0, giving in IDLE after reset:
  - in_ready = 1.
  - out_valid = 0, busy = 0.
  - dp_state = 0, out_block = 0.
  - dp_encrypt = 0, dp_last = 0.
  - rk_idx = NR, since in_encrypt is don't-care at reset and rk_idx follows it combinationally.
- Reset mid-operation: aborts immediately and asynchronously; no output is produced.

## Timing
- Accept edge is edge A.
- dp_result loads occur on edges A+1 through A+NR. out_valid rises after edge A+NR, giving latency NR cycles from accept to out_valid.
- Minimum period between accepts is NR+2 cycles, with out_ready held high.
- out_valid and out_block are stable while out_ready is low. Handshake completes on an edge with out_valid & out_ready.
- rk_idx and dp_last are combinational from registers, except rk_idx in IDLE, which follows in_encrypt. rk and dp_result must settle within the same cycle.
- in_ready is a registered-state decode and does not depend on in_valid or out_ready.

## Structure
- Shared package aes_pkg holds:
  - typedef enum seq_state_t {IDLE, ROUND, DONE}.
  - localparam AES_BLOCK_W = 128.
  - localparam AES128_NR = 10.
- Single module; no sub-module needed.
- Round datapath and key store stay external so the sequencer can be verified against a reference model.

## Test plan
- FIPS-197 App. B encrypt, with the bench supplying a datapath/key model. Key 2b7e151628aed2a6abf7158809cf4f3c, in_block 3243f6a8885a308d313198a2e0370734, in_encrypt=1 → out_valid exactly 10 cycles after accept, out_block 3925841d02dc09fbdc118597196a0b32, rk_idx sequence 0,1..10, dp_last high only at r=10.
- Decrypt of 3925841d02dc09fbdc118597196a0b32 → out_block 3243f6a8885a308d313198a2e0370734; rk_idx sequence 10,9..0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_block constant, in_ready=0, busy=1. Then out_ready=1 → IDLE next cycle and in_ready=1.
- Back-to-back: in_valid held high with two blocks → second accepted exactly 12 cycles after the first; both results correct.
- flush asserted at r=4 → IDLE next edge, in_ready=1, no out_valid pulse. Next block processes correctly.
- rst_n low for 1 cycle at r=7 → immediately in_ready=1, out_valid=0, busy=0, dp_state=0.
